// File: rtl/lectura_if.sv
`default_nettype none
// ============================================================================
// Module      : lectura_if
// Description : Signal bundle for the RTC read-side controller. It groups the
//               system-FSM handshake (iniciar/dir/dato_leido/final/error) and
//               the bus-engine request/response signals (dir_out, data_out,
//               escribe, lee, activa, fin, dato_bus).
//               master : the read controller (lectura)
//               slave  : the environment (system FSM + bus timing engine)
//               "final" is a reserved word in SystemVerilog, so the finished
//               flag is carried as final_flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface lectura_if;
  logic       iniciar;
  logic [7:0] dir;
  logic       fin;
  logic [7:0] dato_bus;
  logic [7:0] dir_out;
  logic [7:0] data_out;
  logic       escribe;
  logic       lee;
  logic       activa;
  logic [7:0] dato_leido;
  logic       final_flag;
  logic       error;

  modport master (
    input  iniciar, dir, fin, dato_bus,
    output dir_out, data_out, escribe, lee, activa,
           dato_leido, final_flag, error
  );

  modport slave (
    output iniciar, dir, fin, dato_bus,
    input  dir_out, data_out, escribe, lee, activa,
           dato_leido, final_flag, error
  );
endinterface
`default_nettype wire

// File: rtl/lectura.sv
`default_nettype none
// ============================================================================
// Module      : lectura
// Description : Read-side controller for the RTC parallel address/data bus.
//               On a level request (iniciar) it optionally issues a transfer
//               command write (0xF1 for clock registers 0x21..0x26, 0xF3 for
//               timer registers 0x41..0x43), then one read cycle, and latches
//               the returned byte. A bus-wait timeout aborts to ERROR.
// Ports       : clk    - system clock
//               reset  - synchronous, active-high reset
//               bus    - lectura_if.master (handshake + bus-engine signals)
// Parameters  : TIMEOUT - bus-wait cycles before abort (< 2**CNT_W)
//               CNT_W   - timeout counter width
// Revision    : 1.0 - initial release
// ============================================================================
module lectura #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  wire logic  clk,
  input  wire logic  reset,
  lectura_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECMD = 3'd1,
    ST_READ   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [7:0]       c_CMD_CLK = 8'hF1;
  localparam logic [7:0]       c_CMD_TMR = 8'hF3;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cmd;
  logic [7:0]       r_dir_out;
  logic [7:0]       r_data_out;
  logic             r_escribe;
  logic             r_lee;
  logic             r_activa;
  logic [7:0]       r_dato_leido;
  logic             r_final;
  logic             r_error;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [7:0]       w_cmd_next;
  logic [7:0]       w_dir_out;
  logic [7:0]       w_data_out;
  logic             w_escribe;
  logic             w_lee;
  logic             w_activa;
  logic [7:0]       w_dato_leido;
  logic             w_final;
  logic             w_error;
  logic             w_is_clk;
  logic             w_is_tmr;

  assign w_is_clk  = (bus.dir >= 8'h21) && (bus.dir <= 8'h26);
  assign w_is_tmr  = (bus.dir >= 8'h41) && (bus.dir <= 8'h43);
  // The increment cannot wrap: TIMEOUT < 2**CNT_W, and the counter is
  // never advanced past TIMEOUT.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state logic followed by output decode of the next state, so the
  // registered outputs always match the state the FSM lands in.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cmd_next   = r_cmd;
    w_dato_leido = r_dato_leido;
    w_dir_out    = 8'h00;
    w_data_out   = 8'h00;
    w_escribe    = 1'b0;
    w_lee        = 1'b0;
    w_activa     = 1'b0;
    w_final      = 1'b0;
    w_error      = 1'b0;

    if (!bus.iniciar) begin
      // Abort beats a coincident fin: nothing is latched.
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cnt_next = '0;
          if (w_is_clk) begin
            w_cmd_next   = c_CMD_CLK;
            w_state_next = ST_PRECMD;
          end else if (w_is_tmr) begin
            w_cmd_next   = c_CMD_TMR;
            w_state_next = ST_PRECMD;
          end else begin
            w_state_next = ST_READ;
          end
        end
        ST_PRECMD: begin
          if (bus.fin) begin
            w_cnt_next   = '0;
            w_state_next = ST_READ;
          end else if (w_cnt_inc == c_TIMEOUT) begin
            w_cnt_next   = '0;
            w_state_next = ST_ERROR;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        ST_READ: begin
          if (bus.fin) begin
            w_dato_leido = bus.dato_bus;
            w_cnt_next   = '0;
            w_state_next = ST_DONE;
          end else if (w_cnt_inc == c_TIMEOUT) begin
            w_cnt_next   = '0;
            w_state_next = ST_ERROR;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
        ST_DONE:  w_state_next = ST_DONE;
        ST_ERROR: w_state_next = ST_ERROR;
        default:  w_state_next = ST_IDLE;
      endcase
    end

    case (w_state_next)
      ST_PRECMD: begin
        w_dir_out  = w_cmd_next;
        w_data_out = w_cmd_next;
        w_escribe  = 1'b1;
        w_activa   = 1'b1;
      end
      ST_READ: begin
        w_dir_out  = bus.dir;
        w_lee      = 1'b1;
        w_activa   = 1'b1;
      end
      ST_DONE: begin
        w_final    = 1'b1;
      end
      ST_ERROR: begin
        w_final    = 1'b1;
        w_error    = 1'b1;
      end
      default: begin
        w_final    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cmd        <= 8'h00;
      r_dir_out    <= 8'h00;
      r_data_out   <= 8'h00;
      r_escribe    <= 1'b0;
      r_lee        <= 1'b0;
      r_activa     <= 1'b0;
      r_dato_leido <= 8'h00;
      r_final      <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_cmd        <= w_cmd_next;
      r_dir_out    <= w_dir_out;
      r_data_out   <= w_data_out;
      r_escribe    <= w_escribe;
      r_lee        <= w_lee;
      r_activa     <= w_activa;
      r_dato_leido <= w_dato_leido;
      r_final      <= w_final;
      r_error      <= w_error;
    end
  end

  assign bus.dir_out    = r_dir_out;
  assign bus.data_out   = r_data_out;
  assign bus.escribe    = r_escribe;
  assign bus.lee        = r_lee;
  assign bus.activa     = r_activa;
  assign bus.dato_leido = r_dato_leido;
  assign bus.final_flag = r_final;
  assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_lectura.sv
`default_nettype none
// ============================================================================
// Module      : tb_lectura
// Description : Self-checking bench for lectura. A table of per-cycle input
//               and expected-output records covers plain, clock and timer
//               reads, address-range boundaries and aborts; hand-written
//               sequences cover timeouts, fin-at-timeout and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lectura;

  localparam int c_TO = 8;

  logic clk;
  logic reset;
  lectura_if bus_if ();

  lectura #(.TIMEOUT(c_TO), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ini;
    logic [7:0]  dir;
    logic        fin;
    logic [7:0]  db;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Expected output bundle:
  // {dir_out, data_out, escribe, lee, activa, dato_leido, final, error}
  function automatic logic [28:0] e_idle(input logic [7:0] dl);
    return {8'h00, 8'h00, 3'b000, dl, 2'b00};
  endfunction
  function automatic logic [28:0] e_pre(input logic [7:0] c, input logic [7:0] dl);
    return {c, c, 3'b101, dl, 2'b00};
  endfunction
  function automatic logic [28:0] e_read(input logic [7:0] d, input logic [7:0] dl);
    return {d, 8'h00, 3'b011, dl, 2'b00};
  endfunction
  function automatic logic [28:0] e_done(input logic [7:0] dl);
    return {8'h00, 8'h00, 3'b000, dl, 2'b10};
  endfunction
  function automatic logic [28:0] e_err(input logic [7:0] dl);
    return {8'h00, 8'h00, 3'b000, dl, 2'b11};
  endfunction

  function automatic logic [28:0] outs();
    return {bus_if.dir_out, bus_if.data_out, bus_if.escribe, bus_if.lee,
            bus_if.activa, bus_if.dato_leido, bus_if.final_flag, bus_if.error};
  endfunction

  task automatic add(input logic ini, input logic [7:0] dir, input logic fin,
                     input logic [7:0] db, input logic [28:0] exp);
    vec_t v;
    v.ini = ini; v.dir = dir; v.fin = fin; v.db = db; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [28:0] exp);
    logic [28:0] act;
    act = outs();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply inputs, let one rising edge happen, sample 1 time unit later.
  task automatic cyc(input logic ini, input logic [7:0] dir, input logic fin,
                     input logic [7:0] db);
    bus_if.iniciar  = ini;
    bus_if.dir      = dir;
    bus_if.fin      = fin;
    bus_if.dato_bus = db;
    @(posedge clk);
    #1;
  endtask

  // Hold a request with no fin and expect c_TO cycles of the wait state,
  // then ERROR with dato_leido untouched.
  task automatic run_timeout(input string name, input logic [7:0] dir,
                             input logic [28:0] wait_exp, input logic [7:0] dl);
    for (int k = 0; k < c_TO; k++) begin
      cyc(1'b1, dir, 1'b0, 8'hEE);
      check($sformatf("%s_wait%0d", name, k), wait_exp);
    end
    cyc(1'b1, dir, 1'b0, 8'hEE);
    check({name, "_err"}, e_err(dl));
    cyc(1'b1, dir, 1'b1, 8'h11);
    check({name, "_err_hold"}, e_err(dl));
    cyc(1'b0, dir, 1'b0, 8'h00);
    check({name, "_release"}, e_idle(dl));
  endtask

  initial begin
    // Plain read of 0x02: five READ cycles then fin with 0x5A.
    add(1, 8'h02, 0, 8'h00, e_read(8'h02, 8'h00));
    for (int k = 0; k < 4; k++) add(1, 8'h02, 0, 8'h00, e_read(8'h02, 8'h00));
    add(1, 8'h02, 1, 8'h5A, e_done(8'h5A));
    add(1, 8'h02, 0, 8'h00, e_done(8'h5A));
    add(1, 8'h02, 1, 8'h33, e_done(8'h5A));   // fin ignored in DONE
    add(0, 8'h02, 0, 8'h00, e_idle(8'h5A));
    add(0, 8'h02, 1, 8'hAA, e_idle(8'h5A));   // fin ignored in IDLE
    // Clock read of 0x23: command 0xF1, then read 0x47.
    add(1, 8'h23, 0, 8'h00, e_pre(8'hF1, 8'h5A));
    add(1, 8'h23, 0, 8'h00, e_pre(8'hF1, 8'h5A));
    add(1, 8'h23, 1, 8'h99, e_read(8'h23, 8'h5A)); // command fin latches nothing
    add(1, 8'h23, 0, 8'h00, e_read(8'h23, 8'h5A));
    add(1, 8'h23, 1, 8'h47, e_done(8'h47));
    add(0, 8'h23, 0, 8'h00, e_idle(8'h47));
    // Timer read of 0x42: command 0xF3, back-to-back fins.
    add(1, 8'h42, 0, 8'h00, e_pre(8'hF3, 8'h47));
    add(1, 8'h42, 1, 8'h00, e_read(8'h42, 8'h47));
    add(1, 8'h42, 1, 8'h3C, e_done(8'h3C));
    add(0, 8'h42, 0, 8'h00, e_idle(8'h3C));
    // Address range edges.
    add(1, 8'h20, 0, 8'h00, e_read(8'h20, 8'h3C));
    add(0, 8'h20, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h21, 0, 8'h00, e_pre(8'hF1, 8'h3C));
    add(0, 8'h21, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h26, 0, 8'h00, e_pre(8'hF1, 8'h3C));
    add(0, 8'h26, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h27, 0, 8'h00, e_read(8'h27, 8'h3C));
    add(0, 8'h27, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h40, 0, 8'h00, e_read(8'h40, 8'h3C));
    add(0, 8'h40, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h41, 0, 8'h00, e_pre(8'hF3, 8'h3C));
    add(0, 8'h41, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h43, 0, 8'h00, e_pre(8'hF3, 8'h3C));
    add(0, 8'h43, 0, 8'h00, e_idle(8'h3C));
    add(1, 8'h44, 0, 8'h00, e_read(8'h44, 8'h3C));
    add(0, 8'h44, 0, 8'h00, e_idle(8'h3C));
    // Abort during PRECMD, then abort in READ coincident with fin.
    add(1, 8'h24, 0, 8'h00, e_pre(8'hF1, 8'h3C));
    add(0, 8'h24, 1, 8'hAA, e_idle(8'h3C));
    add(1, 8'h24, 0, 8'h00, e_pre(8'hF1, 8'h3C));
    add(1, 8'h24, 1, 8'h00, e_read(8'h24, 8'h3C));
    add(0, 8'h24, 1, 8'hAA, e_idle(8'h3C));
    add(0, 8'h24, 0, 8'h00, e_idle(8'h3C));

    reset = 1'b1;
    bus_if.iniciar  = 1'b0;
    bus_if.dir      = 8'h00;
    bus_if.fin      = 1'b0;
    bus_if.dato_bus = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", e_idle(8'h00));
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 8'h00);
    check("post_reset_idle", e_idle(8'h00));

    foreach (vecs[i]) begin
      cyc(vecs[i].ini, vecs[i].dir, vecs[i].fin, vecs[i].db);
      check($sformatf("vec[%0d]", i), vecs[i].exp);
    end

    // Timeout in READ and in PRECMD; dato_leido keeps 0x3C.
    run_timeout("to_read", 8'h10, e_read(8'h10, 8'h3C), 8'h3C);
    run_timeout("to_pre", 8'h22, e_pre(8'hF1, 8'h3C), 8'h3C);

    // fin arriving in the very cycle the counter reaches TIMEOUT wins.
    for (int k = 0; k < c_TO; k++) cyc(1'b1, 8'h10, 1'b0, 8'h00);
    check("fin_at_to_waiting", e_read(8'h10, 8'h3C));
    cyc(1'b1, 8'h10, 1'b1, 8'h77);
    check("fin_at_to_done", e_done(8'h77));
    cyc(1'b0, 8'h10, 1'b0, 8'h00);
    check("fin_at_to_release", e_idle(8'h77));

    // Reset mid-READ with dato_leido = 0x5A.
    cyc(1'b1, 8'h02, 1'b0, 8'h00);
    cyc(1'b1, 8'h02, 1'b1, 8'h5A);
    check("pre_reset_done", e_done(8'h5A));
    cyc(1'b0, 8'h02, 1'b0, 8'h00);
    cyc(1'b1, 8'h03, 1'b0, 8'h00);
    check("pre_reset_read", e_read(8'h03, 8'h5A));
    reset = 1'b1;
    cyc(1'b1, 8'h03, 1'b1, 8'hC3);
    check("reset_mid_read", e_idle(8'h00));
    reset = 1'b0;
    cyc(1'b0, 8'h03, 1'b0, 8'h00);
    check("after_reset_idle", e_idle(8'h00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
